// File: rtl/bus_address_decoder.sv
// Single-master bus address decoder: latches a request, decodes it against a
// static region map, waits for the selected slave with a timeout, and reports completion.
module bus_address_decoder #(
   parameter int NUM_SLAVES     = 3,
   parameter int ADDRESS_WIDTH  = 15,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 15,
   parameter logic [2*NUM_SLAVES*ADDRESS_WIDTH-1:0] REGION_MAP =
      {15'h1000, 15'h1013, 15'h1200, 15'h1200, 15'h2000, 15'h5000}
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               m_req_i,
   input  logic                               m_rd_wr_i,
   input  logic [ADDRESS_WIDTH-1:0]           m_address_i,
   input  logic [DATA_WIDTH-1:0]              m_data_i,
   output logic [DATA_WIDTH-1:0]              m_data_o,
   output logic                               m_ack_o,
   output logic                               m_err_o,
   output logic                               m_busy_o,
   output logic [NUM_SLAVES-1:0]              s_sel_o,
   output logic [ADDRESS_WIDTH-1:0]           s_address_o,
   output logic [DATA_WIDTH-1:0]              s_data_o,
   output logic                               s_rd_wr_o,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_data_i,
   input  logic [NUM_SLAVES-1:0]              s_ack_i,
   input  logic                               clear_counts_i,
   output logic [7:0]                         unmapped_count_o,
   output logic [7:0]                         timeout_count_o
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DECODE, WAIT_ACK, RESP} state_t;

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
   logic                     m_ack_q, m_ack_d;
   logic                     m_err_q, m_err_d;
   logic                     m_busy_q, m_busy_d;
   logic [NUM_SLAVES-1:0]    s_sel_q, s_sel_d;
   logic [ADDRESS_WIDTH-1:0] s_address_q, s_address_d;
   logic [DATA_WIDTH-1:0]    s_data_q, s_data_d;
   logic                     s_rd_wr_q, s_rd_wr_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic [7:0]               unmapped_count_q, unmapped_count_d;
   logic [7:0]               timeout_count_q, timeout_count_d;

   logic                     hit;
   logic [NUM_SLAVES-1:0]    hit_sel;
   logic [ADDRESS_WIDTH-1:0] region_start, region_end;
   logic                     sel_ack;
   logic [DATA_WIDTH-1:0]    sel_data;
   logic                     unmapped_inc, timeout_inc;

   // Scan in ascending slave order so the lowest index wins on overlapping regions.
   always_comb begin
      hit          = 1'b0;
      hit_sel      = '0;
      region_start = '0;
      region_end   = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         region_start = REGION_MAP[(2*NUM_SLAVES-1-2*k)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         region_end   = REGION_MAP[(2*NUM_SLAVES-2-2*k)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         if (!hit && (s_address_q >= region_start) && (s_address_q <= region_end)) begin
            hit        = 1'b1;
            hit_sel[k] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (s_sel_q[k]) sel_data = sel_data | s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      sel_ack = |(s_ack_i & s_sel_q);
   end

   always_comb begin
      state_d      = state_q;
      m_data_d     = m_data_q;
      m_ack_d      = 1'b0;
      m_err_d      = 1'b0;
      s_sel_d      = s_sel_q;
      s_address_d  = s_address_q;
      s_data_d     = s_data_q;
      s_rd_wr_d    = s_rd_wr_q;
      timer_d      = timer_q;
      unmapped_inc = 1'b0;
      timeout_inc  = 1'b0;

      case (state_q)
         IDLE: begin
            if (m_req_i) begin
               s_address_d = m_address_i;
               s_data_d    = m_data_i;
               s_rd_wr_d   = m_rd_wr_i;
               state_d     = DECODE;
            end
         end
         DECODE: begin
            if (hit) begin
               s_sel_d = hit_sel;
               timer_d = '0;
               state_d = WAIT_ACK;
            end else begin
               m_ack_d      = 1'b1;
               m_err_d      = 1'b1;
               unmapped_inc = 1'b1;
               state_d      = RESP;
            end
         end
         WAIT_ACK: begin
            if (sel_ack) begin
               if (!s_rd_wr_q) m_data_d = sel_data;
               s_sel_d = '0;
               m_ack_d = 1'b1;
               state_d = RESP;
            end else if (timer_q == TIMER_LAST) begin
               s_sel_d     = '0;
               m_ack_d     = 1'b1;
               m_err_d     = 1'b1;
               timeout_inc = 1'b1;
               state_d     = RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      m_busy_d = (state_d != IDLE);

      if (clear_counts_i)                            unmapped_count_d = '0;
      else if (unmapped_inc && unmapped_count_q != '1) unmapped_count_d = unmapped_count_q + 8'd1;
      else                                           unmapped_count_d = unmapped_count_q;

      if (clear_counts_i)                            timeout_count_d = '0;
      else if (timeout_inc && timeout_count_q != '1) timeout_count_d = timeout_count_q + 8'd1;
      else                                           timeout_count_d = timeout_count_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q          <= IDLE;
         m_data_q         <= '0;
         m_ack_q          <= 1'b0;
         m_err_q          <= 1'b0;
         m_busy_q         <= 1'b0;
         s_sel_q          <= '0;
         s_address_q      <= '0;
         s_data_q         <= '0;
         s_rd_wr_q        <= 1'b0;
         timer_q          <= '0;
         unmapped_count_q <= '0;
         timeout_count_q  <= '0;
      end else begin
         state_q          <= state_d;
         m_data_q         <= m_data_d;
         m_ack_q          <= m_ack_d;
         m_err_q          <= m_err_d;
         m_busy_q         <= m_busy_d;
         s_sel_q          <= s_sel_d;
         s_address_q      <= s_address_d;
         s_data_q         <= s_data_d;
         s_rd_wr_q        <= s_rd_wr_d;
         timer_q          <= timer_d;
         unmapped_count_q <= unmapped_count_d;
         timeout_count_q  <= timeout_count_d;
      end
   end

   assign m_data_o         = m_data_q;
   assign m_ack_o          = m_ack_q;
   assign m_err_o          = m_err_q;
   assign m_busy_o         = m_busy_q;
   assign s_sel_o          = s_sel_q;
   assign s_address_o      = s_address_q;
   assign s_data_o         = s_data_q;
   assign s_rd_wr_o        = s_rd_wr_q;
   assign unmapped_count_o = unmapped_count_q;
   assign timeout_count_o  = timeout_count_q;

endmodule

// File: tb/tb_bus_address_decoder.sv
// Directed bench for bus_address_decoder with a small reactive slave responder.
module tb_bus_address_decoder;

   localparam int NS = 3;
   localparam int AW = 15;
   localparam int DW = 16;
   localparam int TO = 15;

   logic              clk_i = 1'b0;
   logic              reset_n_i = 1'b0;
   logic              m_req_i = 1'b0;
   logic              m_rd_wr_i = 1'b0;
   logic [AW-1:0]     m_address_i = '0;
   logic [DW-1:0]     m_data_i = '0;
   logic [DW-1:0]     m_data_o;
   logic              m_ack_o, m_err_o, m_busy_o;
   logic [NS-1:0]     s_sel_o;
   logic [AW-1:0]     s_address_o;
   logic [DW-1:0]     s_data_o;
   logic              s_rd_wr_o;
   logic [NS*DW-1:0]  s_data_i = '0;
   logic [NS-1:0]     s_ack_i = '0;
   logic              clear_counts_i = 1'b0;
   logic [7:0]        unmapped_count_o, timeout_count_o;

   bus_address_decoder #(
      .NUM_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .m_req_i(m_req_i), .m_rd_wr_i(m_rd_wr_i), .m_address_i(m_address_i), .m_data_i(m_data_i),
      .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_busy_o(m_busy_o),
      .s_sel_o(s_sel_o), .s_address_o(s_address_o), .s_data_o(s_data_o), .s_rd_wr_o(s_rd_wr_o),
      .s_data_i(s_data_i), .s_ack_i(s_ack_i), .clear_counts_i(clear_counts_i),
      .unmapped_count_o(unmapped_count_o), .timeout_count_o(timeout_count_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int passes = 0;

   // Responder: acks on the rsp_delay-th cycle its slave is selected (0 = never); rogue bits always driven.
   int            rsp_slave = 0;
   int            rsp_delay = 0;
   int            rsp_cnt = 0;
   logic [NS-1:0] rogue = '0;

   initial forever begin
      @(posedge clk_i);
      #2;
      if (rsp_delay != 0 && s_sel_o[rsp_slave]) begin
         rsp_cnt++;
         s_ack_i = rogue;
         if (rsp_cnt == rsp_delay) s_ack_i[rsp_slave] = 1'b1;
      end else begin
         rsp_cnt = 0;
         s_ack_i = rogue;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
   endtask

   // Issues one request, waits (bounded) for m_ack_o, then steps one more cycle back to IDLE.
   task automatic run_txn(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d,
                          input logic hold_req, output int lat, output logic [NS-1:0] sel_seen,
                          output logic err_at_ack, output logic stray_err);
      m_req_i = 1'b1; m_address_i = a; m_rd_wr_i = rw; m_data_i = d;
      tick();
      m_req_i = hold_req; m_address_i = 15'h7FFF; m_rd_wr_i = ~rw; m_data_i = 16'hFFFF;
      lat = 1; sel_seen = s_sel_o; stray_err = 1'b0;
      while (!m_ack_o && lat < 60) begin
         if (m_err_o) stray_err = 1'b1;
         tick();
         lat++;
         sel_seen = sel_seen | s_sel_o;
      end
      err_at_ack = m_err_o;
      m_req_i = 1'b0;
      tick();
   endtask

   int            lat;
   logic [NS-1:0] sel_seen;
   logic          err_at_ack, stray_err, ack_seen;

   initial begin
      s_data_i = {16'h2222, 16'h1111, 16'hA55A};
      repeat (3) tick();
      chk("rst_m_data", m_data_o, 0);
      chk("rst_m_ack", m_ack_o, 0);
      chk("rst_m_err", m_err_o, 0);
      chk("rst_busy", m_busy_o, 0);
      chk("rst_sel", s_sel_o, 0);
      chk("rst_s_addr", s_address_o, 0);
      chk("rst_s_data", s_data_o, 0);
      chk("rst_rd_wr", s_rd_wr_o, 0);
      chk("rst_ucnt", unmapped_count_o, 0);
      chk("rst_tcnt", timeout_count_o, 0);

      // Request presented together with reset release is accepted on the first edge.
      rsp_slave = 0; rsp_delay = 1; rogue = 3'b110;
      reset_n_i = 1'b1;
      run_txn(15'h1005, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("rd0_lat", lat, 3);
      chk("rd0_sel", sel_seen, 3'b001);
      chk("rd0_err", err_at_ack, 0);
      chk("rd0_stray_err", stray_err, 0);
      chk("rd0_data", m_data_o, 16'hA55A);
      chk("rd0_ack_done", m_ack_o, 0);
      chk("rd0_idle", m_busy_o, 0);

      // Write with late ack; m_req_i held high throughout must not queue a second access.
      rsp_slave = 1; rsp_delay = 4; rogue = '0;
      run_txn(15'h1200, 1'b1, 16'h0001, 1'b1, lat, sel_seen, err_at_ack, stray_err);
      chk("wr1_lat", lat, 6);
      chk("wr1_sel", sel_seen, 3'b010);
      chk("wr1_err", err_at_ack, 0);
      chk("wr1_s_data", s_data_o, 16'h0001);
      chk("wr1_s_addr", s_address_o, 15'h1200);
      chk("wr1_rd_wr", s_rd_wr_o, 1);
      chk("wr1_m_data_held", m_data_o, 16'hA55A);
      chk("wr1_no_requeue_busy", m_busy_o, 0);
      chk("wr1_no_requeue_ucnt", unmapped_count_o, 0);

      run_txn(15'h0500, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("unm_lat", lat, 2);
      chk("unm_err", err_at_ack, 1);
      chk("unm_sel", sel_seen, 0);
      chk("unm_ucnt", unmapped_count_o, 1);
      chk("unm_m_data_held", m_data_o, 16'hA55A);

      // Silent slave 2 while the other slaves ack constantly.
      rsp_slave = 2; rsp_delay = 0; rogue = 3'b011;
      run_txn(15'h3000, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("to_lat", lat, 2 + TO);
      chk("to_sel", sel_seen, 3'b100);
      chk("to_err", err_at_ack, 1);
      chk("to_stray_err", stray_err, 0);
      chk("to_tcnt", timeout_count_o, 1);
      chk("to_m_data_held", m_data_o, 16'hA55A);

      s_data_i = {16'hBEEF, 16'h1111, 16'hA55A};
      rsp_delay = TO; rogue = '0;
      run_txn(15'h3000, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("ack15_lat", lat, 2 + TO);
      chk("ack15_err", err_at_ack, 0);
      chk("ack15_data", m_data_o, 16'hBEEF);
      chk("ack15_tcnt", timeout_count_o, 1);

      // Region boundaries.
      s_data_i = {16'h2222, 16'h1111, 16'h0F0F};
      rsp_slave = 0; rsp_delay = 1;
      run_txn(15'h1013, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("b1013_sel", sel_seen, 3'b001);
      chk("b1013_data", m_data_o, 16'h0F0F);
      run_txn(15'h1014, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("b1014_err", err_at_ack, 1);
      chk("b1014_ucnt", unmapped_count_o, 2);
      rsp_slave = 2;
      run_txn(15'h5000, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("b5000_sel", sel_seen, 3'b100);
      chk("b5000_data", m_data_o, 16'h2222);
      run_txn(15'h5001, 1'b1, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("b5001_err", err_at_ack, 1);
      chk("b5001_ucnt", unmapped_count_o, 3);
      chk("b5001_m_data_held", m_data_o, 16'h2222);

      for (int i = 0; i < 256; i++)
         run_txn(15'h7000, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("sat_ucnt", unmapped_count_o, 255);
      chk("sat_tcnt", timeout_count_o, 1);

      // Clear asserted on the same edge as an unmapped increment.
      m_req_i = 1'b1; m_address_i = 15'h0000; m_rd_wr_i = 1'b0;
      tick();
      m_req_i = 1'b0; clear_counts_i = 1'b1;
      tick();
      clear_counts_i = 1'b0;
      chk("clr_ack", m_ack_o, 1);
      chk("clr_err", m_err_o, 1);
      chk("clr_ucnt", unmapped_count_o, 0);
      chk("clr_tcnt", timeout_count_o, 0);
      tick();
      run_txn(15'h0001, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("clr_next_ucnt", unmapped_count_o, 1);

      // Asynchronous reset while waiting on a silent slave.
      rsp_slave = 2; rsp_delay = 0;
      m_req_i = 1'b1; m_address_i = 15'h3000; m_rd_wr_i = 1'b0;
      tick();
      m_req_i = 1'b0;
      tick();
      tick();
      chk("mid_busy", m_busy_o, 1);
      chk("mid_sel", s_sel_o, 3'b100);
      reset_n_i = 1'b0;
      #1;
      chk("arst_busy", m_busy_o, 0);
      chk("arst_sel", s_sel_o, 0);
      chk("arst_m_data", m_data_o, 0);
      chk("arst_s_addr", s_address_o, 0);
      chk("arst_ucnt", unmapped_count_o, 0);
      chk("arst_tcnt", timeout_count_o, 0);
      ack_seen = m_ack_o;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) reset_n_i = 1'b1;
         tick();
         ack_seen = ack_seen | m_ack_o;
      end
      chk("arst_no_ack", ack_seen, 0);
      s_data_i = {16'h2222, 16'h1111, 16'h5A5A};
      rsp_slave = 0; rsp_delay = 1;
      run_txn(15'h1005, 1'b0, 16'h0000, 1'b0, lat, sel_seen, err_at_ack, stray_err);
      chk("post_lat", lat, 3);
      chk("post_err", err_at_ack, 0);
      chk("post_data", m_data_o, 16'h5A5A);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/bus_address_decoder.md
BUS_ADDRESS_DECODER -- requirements
Module: bus_address_decoder

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 3, meaning number of slave regions (1..16).
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 15, meaning bus address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, meaning bus data width (CRC excluded).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 15, meaning max WAIT_ACK cycles before error (>=1).
REQ-005 The block SHALL have parameter REGION_MAP, width 2*NUM_SLAVES*ADDRESS_WIDTH, default {'h1000,'h1013,'h1200,'h1200,'h2000,'h5000}, meaning per-slave {start,end} pairs, slave 0 leftmost, start left of end, both inclusive.
REQ-006 clk_i  input  1  system clock; all logic is in this single clock domain.
REQ-007 reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-008 m_req_i  input  1  master transaction request, single-cycle pulse.
REQ-009 m_rd_wr_i  input  1  1 = write, 0 = read.
REQ-010 m_address_i  input  ADDRESS_WIDTH  master address.
REQ-011 m_data_i  input  DATA_WIDTH  master write data.
REQ-012 m_data_o  output  DATA_WIDTH  registered read data.
REQ-013 m_ack_o  output  1  one-cycle completion pulse.
REQ-014 m_err_o  output  1  error flag, valid only while m_ack_o=1.
REQ-015 m_busy_o  output  1  high whenever FSM is not IDLE.
REQ-016 s_sel_o  output  NUM_SLAVES  one-hot slave select.
REQ-017 s_address_o / s_data_o / s_rd_wr_o  output  ADDRESS_WIDTH / DATA_WIDTH / 1  latched transaction fields to all slaves.
REQ-018 s_data_i  input  NUM_SLAVES*DATA_WIDTH  slave read data, slave k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-019 s_ack_i  input  NUM_SLAVES  per-slave completion.
REQ-020 clear_counts_i  input  1  synchronous clear of both status counters.
REQ-021 unmapped_count_o / timeout_count_o  output  8 / 8  saturating error counters.

Function
REQ-022 The FSM SHALL have states IDLE, DECODE, WAIT_ACK, RESP.
REQ-023 In IDLE with m_req_i=1, the block SHALL latch address, data and rd_wr into s_*_o and enter DECODE next cycle.
REQ-024 m_req_i outside IDLE SHALL be ignored: no queueing, no error.
REQ-025 DECODE SHALL match the latched address against every region (start <= addr <= end); on overlap, the lowest slave index SHALL win.
REQ-026 On a hit, the FSM SHALL enter WAIT_ACK with s_sel_o one-hot for the hit slave; s_sel_o SHALL be zero in all other states.
REQ-027 On no hit, the FSM SHALL enter RESP with error set and SHALL increment unmapped_count_o.
REQ-028 The WAIT_ACK timer SHALL clear on entry and increment each cycle without the selected ack.
REQ-029 s_ack_i of the selected slave SHALL complete the transaction: a read captures that slave's s_data_i into m_data_o; both reads and writes then go to RESP without error.
REQ-030 An ack on the TIMEOUT_CYCLES-th WAIT_ACK cycle SHALL count as success.
REQ-031 With no ack after TIMEOUT_CYCLES cycles, the FSM SHALL enter RESP with error and SHALL increment timeout_count_o.
REQ-032 s_ack_i from unselected slaves, or in any state other than WAIT_ACK, SHALL be ignored.
REQ-033 In RESP, m_ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-034 m_err_o SHALL be 0 whenever m_ack_o=0.
REQ-035 m_data_o SHALL be held until the next successful read; writes and errored reads SHALL leave it unchanged.
REQ-036 Latency: a mapped read with an immediate ack SHALL produce m_ack_o 3 cycles after m_req_i; an unmapped access SHALL produce it 2 cycles after.
REQ-037 Counters SHALL saturate at 255.
REQ-038 clear_counts_i SHALL win over a simultaneous increment.

Reset
REQ-039 When reset_n_i=0, the block SHALL immediately force: FSM to IDLE, m_data_o=0, m_ack_o=0, m_err_o=0, m_busy_o=0, s_sel_o=0, s_address_o=0, s_data_o=0, s_rd_wr_o=0, timer=0, both counters=0.
REQ-040 A reset mid-transaction SHALL abort the transaction without producing m_ack_o.
REQ-041 The first m_req_i accepted SHALL be the one in the first clock edge after reset_n_i deasserts.

Verification
REQ-042 Read 'h1005 with slave 0 acking in its first WAIT_ACK cycle, data 'hA55A -> s_sel_o=3'b001, m_ack_o 3 cycles after request, m_data_o='hA55A, m_err_o=0.
REQ-043 Write 'h1200 data 'h0001 with slave 1 acking after 4 cycles -> s_sel_o=3'b010, s_data_o='h0001, m_err_o=0, m_data_o unchanged.
REQ-044 Read 'h0500 (unmapped) -> m_ack_o 2 cycles after request, m_err_o=1, unmapped_count_o increments 0->1, s_sel_o stays 0.
REQ-045 Read 'h3000 with slave 2 silent -> m_ack_o after TIMEOUT_CYCLES=15 WAIT_ACK cycles, m_err_o=1, timeout_count_o=1; a repeat where slave 2 acks on cycle 15 -> m_err_o=0.
REQ-046 256 unmapped accesses -> unmapped_count_o=255; clear_counts_i asserted together with a further increment -> unmapped_count_o=0.
REQ-047 reset_n_i pulsed low during WAIT_ACK -> outputs at reset values immediately, no m_ack_o; a new request after release completes normally.
